frame_crc: RTL



---
 rtl/frame_crc_pkg.sv | 41 ++++
 rtl/frame_crc.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_crc_pkg.sv
// ----------------------------------------------------------------------------
// frame_crc_pkg
// Shared definitions for the frame signature checker and other trace
// checkers that need the same byte-wise CRC-32 fold.
//   CRC32_POLY / CRC32_INIT / CRC32_XOROUT : reflected CRC-32 constants
//   PIX_CNT_W                             : width of the per-frame pixel count
//   frame_crc_state_t                     : frame tracking states
//   crc32_byte(crc, d)                    : folds one byte, bit 0 first
// ----------------------------------------------------------------------------
package frame_crc_pkg;

    localparam logic [31:0] CRC32_POLY   = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;

    // 256*240 active pixels needs 16 bits; one spare bit keeps an overlong
    // frame visibly larger than a legal one before saturation kicks in.
    localparam int PIX_CNT_W = 17;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        BLANK  = 2'd1,
        ACTIVE = 2'd2
    } frame_crc_state_t;

    // Reflected CRC: the register shifts right and the data is consumed
    // LSB first, so the polynomial is applied on the outgoing bit 0.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) begin
                c = (c >> 1) ^ CRC32_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/frame_crc.sv
// ----------------------------------------------------------------------------
// frame_crc
// Accumulates a CRC-32 over every active pixel of a video frame and publishes
// the signature, pixel count and geometry status on each vblank rising edge.
//
// Ports:
//   clk            in   pixel clock
//   rst            in   synchronous active-high reset
//   pixel[7:0]     in   palette index
//   pixel_en       in   pixel valid qualifier
//   vblank         in   vertical blank level
//   crc[31:0]      out  CRC of the last completed frame
//   crc_valid      out  one-cycle pulse when crc/pix_cnt/frame_ok update
//   pix_cnt[16:0]  out  pixel count of the last completed frame
//   frame_ok       out  last frame had H_ACTIVE*V_ACTIVE pixels and no error
//   frame_cnt      out  completed frame counter, wraps
//   err_vblank_pix out  sticky: pixel_en seen during blanking
//   line_err       out  sticky line geometry error (FRAME_CRC_LINE_CHECK_EN only)
//   synced         out  first vblank rising edge has been seen
//
// Build option: define FRAME_CRC_LINE_CHECK_EN to add per-line run length and
// line count checking, plus the line_err output.
// ----------------------------------------------------------------------------
module frame_crc
    import frame_crc_pkg::*;
#(
    parameter int H_ACTIVE    = 256,
    parameter int V_ACTIVE    = 240,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             pixel,
    input  logic                   pixel_en,
    input  logic                   vblank,
    output logic [31:0]            crc,
    output logic                   crc_valid,
    output logic [PIX_CNT_W-1:0]   pix_cnt,
    output logic                   frame_ok,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   err_vblank_pix,
`ifdef FRAME_CRC_LINE_CHECK_EN
    output logic                   line_err,
`endif
    output logic                   synced
);

    localparam logic [PIX_CNT_W-1:0]   FRAME_PIX = PIX_CNT_W'(H_ACTIVE * V_ACTIVE);
    localparam logic [PIX_CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [PIX_CNT_W-1:0]   CNT_ONE   = PIX_CNT_W'(1);
    localparam logic [FRAME_CNT_W-1:0] FCNT_ONE  = FRAME_CNT_W'(1);

    frame_crc_state_t       r_state;
    frame_crc_state_t       w_next_state;
    logic                   r_vblank_q;
    logic [31:0]            r_acc;
    logic [PIX_CNT_W-1:0]   r_run_cnt;
    logic                   r_frame_err;
    logic [31:0]            r_crc;
    logic                   r_crc_valid;
    logic [PIX_CNT_W-1:0]   r_pix_cnt;
    logic                   r_frame_ok;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    logic                   r_err_vblank_pix;
    logic                   r_synced;

    logic                   w_vblank_rise;
    logic                   w_sync_hit;
    logic                   w_publish;
    logic                   w_fold;
    logic                   w_blank_pix;
    logic [31:0]            w_acc_fold;
    logic [PIX_CNT_W-1:0]   w_cnt_fold;
    logic                   w_geom_bad;
    logic                   w_frame_err_now;

    assign w_vblank_rise = vblank & ~r_vblank_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_sync_hit   = 1'b0;
        w_publish    = 1'b0;
        w_fold       = 1'b0;
        w_blank_pix  = 1'b0;
        case (r_state)
            SYNC: begin
                if (w_vblank_rise) begin
                    w_next_state = BLANK;
                    w_sync_hit   = 1'b1;
                end
            end
            BLANK: begin
                w_blank_pix = pixel_en;
                if (!vblank) begin
                    w_next_state = ACTIVE;
                end
            end
            ACTIVE: begin
                w_fold = pixel_en;
                if (w_vblank_rise) begin
                    w_next_state = BLANK;
                    w_publish    = 1'b1;
                end
            end
            default: begin
                w_next_state = SYNC;
            end
        endcase
    end

    // The fold is computed ahead of the publish decision so a pixel arriving
    // on the vblank rising edge still lands in the published frame.
    assign w_acc_fold = w_fold ? crc32_byte(r_acc, pixel) : r_acc;
    assign w_cnt_fold = (w_fold && (r_run_cnt != CNT_MAX)) ? r_run_cnt + CNT_ONE : r_run_cnt;

`ifdef FRAME_CRC_LINE_CHECK_EN
    localparam int                      LINE_CNT_W = 9;
    localparam logic [LINE_CNT_W-1:0]   LINE_MAX   = '1;
    localparam logic [LINE_CNT_W-1:0]   LINE_ONE   = LINE_CNT_W'(1);
    localparam logic [LINE_CNT_W-1:0]   V_LINES    = LINE_CNT_W'(V_ACTIVE);
    localparam logic [PIX_CNT_W-1:0]    H_PIX      = PIX_CNT_W'(H_ACTIVE);

    logic [PIX_CNT_W-1:0]  r_run_len;
    logic [PIX_CNT_W-1:0]  w_run_len;
    logic [LINE_CNT_W-1:0] r_line_cnt;
    logic [LINE_CNT_W-1:0] w_line_cnt;
    logic                  w_run_end;
    logic                  r_line_err;

    // A run closes on the pixel_en falling edge, or at publish if pixels
    // are still streaming when vblank rises.
    assign w_run_len  = (w_fold && (r_run_len != CNT_MAX)) ? r_run_len + CNT_ONE : r_run_len;
    assign w_run_end  = (r_state == ACTIVE) &&
                        ((!pixel_en && (r_run_len != '0)) || (w_publish && pixel_en));
    assign w_line_cnt = (w_run_end && (r_line_cnt != LINE_MAX)) ? r_line_cnt + LINE_ONE : r_line_cnt;
    assign w_geom_bad = (w_run_end && (w_run_len != H_PIX)) ||
                        (w_publish && (w_line_cnt != V_LINES));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_len  <= '0;
            r_line_cnt <= '0;
            r_line_err <= 1'b0;
        end else begin
            if (w_sync_hit || w_publish) begin
                r_run_len  <= '0;
                r_line_cnt <= '0;
            end else begin
                r_run_len  <= w_run_end ? '0 : w_run_len;
                r_line_cnt <= w_line_cnt;
            end
            if (w_geom_bad) begin
                r_line_err <= 1'b1;
            end
        end
    end

    assign line_err = r_line_err;
`else
    assign w_geom_bad = 1'b0;
`endif

    assign w_frame_err_now = r_frame_err | w_blank_pix | w_geom_bad;

    // Accumulator, frame status and the published results.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vblank_q       <= 1'b0;
            r_acc            <= CRC32_INIT;
            r_run_cnt        <= '0;
            r_frame_err      <= 1'b0;
            r_crc            <= '0;
            r_crc_valid      <= 1'b0;
            r_pix_cnt        <= '0;
            r_frame_ok       <= 1'b0;
            r_frame_cnt      <= '0;
            r_err_vblank_pix <= 1'b0;
            r_synced         <= 1'b0;
        end else begin
            r_vblank_q  <= vblank;
            r_crc_valid <= 1'b0;
            if (w_sync_hit) begin
                r_synced    <= 1'b1;
                r_acc       <= CRC32_INIT;
                r_run_cnt   <= '0;
                r_frame_err <= 1'b0;
            end else if (w_publish) begin
                r_crc       <= w_acc_fold ^ CRC32_XOROUT;
                r_pix_cnt   <= w_cnt_fold;
                r_crc_valid <= 1'b1;
                r_frame_ok  <= (w_cnt_fold == FRAME_PIX) && !w_frame_err_now;
                r_frame_cnt <= r_frame_cnt + FCNT_ONE;
                r_acc       <= CRC32_INIT;
                r_run_cnt   <= '0;
                r_frame_err <= 1'b0;
            end else begin
                r_acc       <= w_acc_fold;
                r_run_cnt   <= w_cnt_fold;
                r_frame_err <= w_frame_err_now;
            end
            if (w_blank_pix) begin
                r_err_vblank_pix <= 1'b1;
            end
        end
    end

    assign crc            = r_crc;
    assign crc_valid      = r_crc_valid;
    assign pix_cnt        = r_pix_cnt;
    assign frame_ok       = r_frame_ok;
    assign frame_cnt      = r_frame_cnt;
    assign err_vblank_pix = r_err_vblank_pix;
    assign synced         = r_synced;

endmodule
